mem_lsu: RTL

- Parametrised, sequential load/store unit for the MEM stage; successor to the combinational MEM block.
- Accepts one memory op at a time from EX/MEM and issues a valid/ready request to the D-cache. Stores use byte strobes, so there is no read-modify-write.
- Formats load data (sign/zero extend) and returns one writeback beat to MEM/WB. Raises hold to ctrl while busy, flags misaligned accesses, and honours interrupt flush.

---
 rtl/mem_lsu_pkg.sv | 41 ++++
 rtl/lsu_data_align.sv | 70 +++++++
 rtl/mem_lsu.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM states,
// fault cause codes and the access-legality check applied when an op is captured.
package mem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_e;

    // True when the width is legal for this XLEN and the address is naturally aligned.
    function automatic logic access_ok(input logic [2:0] funct3, input logic is_load,
                                       input logic [2:0] lo, input logic xlen64);
        logic ok;
        case (funct3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~lo[0];
            2'b10:   ok = (lo[1:0] == 2'b00);
            default: ok = (lo == 3'b000) && xlen64;
        endcase
        if (funct3[2]) begin
            if (!is_load || funct3[1:0] == 2'b11) ok = 1'b0;
            else if (funct3[1:0] == 2'b10 && !xlen64) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering for stores (strobes + replicated data) and extraction with
// sign/zero extension for loads. Purely combinational.
module lsu_data_align
    import mem_lsu_pkg::*;
#(
    parameter int XLEN = 64
)(
    input  logic [2:0]              funct3,
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [XLEN-1:0]         st_data,
    input  logic [XLEN-1:0]         ld_word,
    output logic [XLEN/8-1:0]       st_strb,
    output logic [XLEN-1:0]         st_lane,
    output logic [XLEN-1:0]         ld_data
);
    localparam int STRB_W = XLEN / 8;

    logic [XLEN-1:0] shifted;

    function automatic logic [XLEN-1:0] ext8(input logic [7:0] v, input logic sgn);
        return sgn ? XLEN'($signed(v)) : XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] ext16(input logic [15:0] v, input logic sgn);
        return sgn ? XLEN'($signed(v)) : XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
        return sgn ? XLEN'($signed(v)) : XLEN'(v);
    endfunction

    // Store data is replicated across every lane, so the strobe alone selects the target bytes.
    always_comb begin
        st_strb = '1;
        st_lane = st_data;
        case (funct3[1:0])
            2'b00: begin
                st_strb = STRB_W'(1) << off;
                st_lane = {STRB_W{st_data[7:0]}};
            end
            2'b01: begin
                st_strb = STRB_W'(3) << off;
                st_lane = {(STRB_W/2){st_data[15:0]}};
            end
            2'b10: begin
                st_strb = STRB_W'(4'hF) << off;
                st_lane = {(STRB_W/4){st_data[31:0]}};
            end
            default: begin
                st_strb = '1;
                st_lane = st_data;
            end
        endcase
    end

    assign shifted = ld_word >> {off, 3'b000};

    always_comb begin
        case (funct3)
            F3_B:    ld_data = ext8(shifted[7:0], 1'b1);
            F3_BU:   ld_data = ext8(shifted[7:0], 1'b0);
            F3_H:    ld_data = ext16(shifted[15:0], 1'b1);
            F3_HU:   ld_data = ext16(shifted[15:0], 1'b0);
            F3_W:    ld_data = ext32(shifted[31:0], 1'b1);
            F3_WU:   ld_data = ext32(shifted[31:0], 1'b0);
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Sequential MEM-stage load/store unit: one op at a time, valid/ready D-cache request,
// formatted single-beat writeback, misalignment faults and interrupt flush.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int ADDR_W       = 32,
    parameter int CACHE_ADDR_W = 12,
    parameter int RD_W         = 5,
    parameter int STRB_W       = XLEN / 8,
    parameter int OFF_W        = $clog2(XLEN / 8)
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_load_i,
    input  logic                    req_store_i,
    input  logic [2:0]              req_funct3_i,
    input  logic [ADDR_W-1:0]       req_addr_i,
    input  logic [XLEN-1:0]         req_wdata_i,
    input  logic [RD_W-1:0]         req_rd_i,
    input  logic                    int_assert_i,
    output logic                    hold_o,
    output logic                    dc_req_valid_o,
    input  logic                    dc_req_ready_i,
    output logic                    dc_req_rw_o,
    output logic [CACHE_ADDR_W-1:0] dc_req_addr_o,
    output logic [XLEN-1:0]         dc_req_wdata_o,
    output logic [STRB_W-1:0]       dc_req_strb_o,
    input  logic                    dc_rsp_valid_i,
    input  logic [XLEN-1:0]         dc_rsp_rdata_i,
    output logic                    wb_valid_o,
    output logic [RD_W-1:0]         wb_rd_o,
    output logic [XLEN-1:0]         wb_data_o,
    output logic                    fault_o,
    output logic [ADDR_W-1:0]       fault_addr_o
);
    state_e state, state_n;

    logic              load_p0, store_p0, flush_p0;
    logic [2:0]        funct3_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [XLEN-1:0]   wdata_p0;
    logic [RD_W-1:0]   rd_p0;
    logic [XLEN-1:0]   rdata_p1;
    logic              accept, legal;
    logic [STRB_W-1:0] strb_lane;
    logic [XLEN-1:0]   wdata_lane, load_fmt;

    assign accept = req_valid_i & req_ready_o & (req_load_i | req_store_i) & ~int_assert_i;
    assign legal  = access_ok(req_funct3_i, req_load_i, req_addr_i[2:0], XLEN == 64);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = legal ? S_REQ : S_FAULT;
            S_REQ: begin
                if (int_assert_i)        state_n = S_IDLE;
                else if (dc_req_ready_i) state_n = S_WAIT;
            end
            S_WAIT:  if (dc_rsp_valid_i) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            S_FAULT: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // p0: op captured on accept; p1: response word captured in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_p0   <= 1'b0;
            store_p0  <= 1'b0;
            flush_p0  <= 1'b0;
            funct3_p0 <= '0;
            addr_p0   <= '0;
            wdata_p0  <= '0;
            rd_p0     <= '0;
            rdata_p1  <= '0;
        end else begin
            if (accept) begin
                load_p0   <= req_load_i;
                store_p0  <= ~req_load_i;
                flush_p0  <= 1'b0;
                funct3_p0 <= req_funct3_i;
                addr_p0   <= req_addr_i;
                wdata_p0  <= req_wdata_i;
                rd_p0     <= req_rd_i;
            end
            // A flush seen while waiting lets the access finish but kills its writeback.
            if (state == S_WAIT && int_assert_i)   flush_p0 <= 1'b1;
            if (state == S_WAIT && dc_rsp_valid_i) rdata_p1 <= dc_rsp_rdata_i;
        end
    end

    lsu_data_align #(.XLEN(XLEN)) u_align (
        .funct3  (funct3_p0),
        .off     (addr_p0[OFF_W-1:0]),
        .st_data (wdata_p0),
        .ld_word (rdata_p1),
        .st_strb (strb_lane),
        .st_lane (wdata_lane),
        .ld_data (load_fmt)
    );

    assign req_ready_o    = (state == S_IDLE);
    assign hold_o         = (state == S_REQ) | (state == S_WAIT) | (state == S_FAULT) | accept;
    assign dc_req_valid_o = (state == S_REQ) & ~int_assert_i;
    assign dc_req_rw_o    = store_p0;
    assign dc_req_addr_o  = addr_p0[CACHE_ADDR_W+OFF_W-1:OFF_W];
    assign dc_req_wdata_o = wdata_lane;
    assign dc_req_strb_o  = store_p0 ? strb_lane : '0;
    assign wb_valid_o     = (state == S_DONE) & load_p0 & ~flush_p0 & ~int_assert_i;
    assign wb_rd_o        = rd_p0;
    assign wb_data_o      = load_fmt;
    assign fault_o        = (state == S_FAULT);
    assign fault_addr_o   = addr_p0;

endmodule
